// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo encoder output path.
// Word geometry, packer FSM states and the default code-block length.
package turbo_pkg;

  localparam int PAIRS_PER_WORD  = 4;
  localparam int WORD_W          = 8;
  localparam int DEF_BLOCK_PAIRS = 6150;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FLUSH
  } state_e;

endpackage

// File: rtl/turbo_word_fifo.sv
// Word FIFO for the output packer: {last, data} entries,
// wrap-bit pointers, output taken straight from the storage flops.
module turbo_word_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         wr_en, rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  assign wr_d = wr_en ? wr_q + 1'b1 : wr_q;
  assign rd_d = rd_en ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/turbo_output_packer.sv
// Packs encoder (out0, out1) pairs into bytes, pads the block tail,
// and streams words out through a small FIFO with a block-last flag.
module turbo_output_packer
  import turbo_pkg::*;
#(
  parameter int BLOCK_PAIRS = DEF_BLOCK_PAIRS,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic              in_out0,
  input  logic              in_out1,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              overflow,
  output logic              blk_done,
  output logic [15:0]       blk_count
);

  localparam int SW = $clog2(PAIRS_PER_WORD);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              push_q, push_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       blk_q, blk_d;

  logic              cap, is_last, pop, full, empty;
  logic [SW-1:0]     slot;

  assign cap     = in_valid && enable;
  assign slot    = cnt_q[SW-1:0];
  assign is_last = (cnt_q == CNT_W'(BLOCK_PAIRS - 1));
  assign pop     = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    push_d  = 1'b0;
    blk_d   = blk_q;
    ovf_d   = ovf_q | (push_q && full && !pop);
    if (cap) begin
      // Fresh word starts zeroed so a short tail is padded for free.
      if (slot == '0) word_d = '0;
      word_d[{slot, 1'b0} +: 2] = {in_out1, in_out0};
      cnt_d  = is_last ? '0 : cnt_q + 1'b1;
      push_d = is_last || (slot == SW'(PAIRS_PER_WORD - 1));
    end
    unique case (state_q)
      IDLE, PACK: begin
        if (cap) state_d = is_last ? FLUSH : PACK;
      end
      FLUSH: begin
        blk_d = blk_q + 1'b1;
        if (cap) state_d = is_last ? FLUSH : PACK;
        else     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      push_q  <= 1'b0;
      ovf_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      push_q  <= push_d;
      ovf_q   <= ovf_d;
      blk_q   <= blk_d;
    end
  end

  turbo_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push_q),
    .data_i  ({state_q == FLUSH, word_q}),
    .pop_i   (pop),
    .data_o  ({m_last, m_data}),
    .full_o  (full),
    .empty_o (empty)
  );

  assign m_valid   = !empty;
  assign overflow  = ovf_q;
  assign blk_done  = (state_q == FLUSH);
  assign blk_count = blk_q;

endmodule

// File: tb/tb_turbo_output_packer.sv
// Scoreboard bench for the output packer: three instances with
// different block lengths, one driven at a time.
module tb_turbo_output_packer;

  localparam int NI    = 3;
  localparam int DEPTH = 16;
  localparam int BPS [NI] = '{6150, 8, 6};

  logic        clk = 1'b0;
  logic        rst;
  logic        en   [NI];
  logic        vld  [NI];
  logic        d0   [NI];
  logic        d1   [NI];
  logic        rdy  [NI];
  logic [7:0]  mdat [NI];
  logic        mvld [NI];
  logic        mlst [NI];
  logic        ovf  [NI];
  logic        bdn  [NI];
  logic [15:0] bcnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    turbo_output_packer #(
      .BLOCK_PAIRS (BPS[g]),
      .FIFO_DEPTH  (DEPTH),
      .CNT_W       (13)
    ) u_dut (
      .clk       (clk),
      .reset     (rst),
      .enable    (en[g]),
      .in_valid  (vld[g]),
      .in_out0   (d0[g]),
      .in_out1   (d1[g]),
      .m_data    (mdat[g]),
      .m_valid   (mvld[g]),
      .m_last    (mlst[g]),
      .m_ready   (rdy[g]),
      .overflow  (ovf[g]),
      .blk_done  (bdn[g]),
      .blk_count (bcnt[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cur    = 0;
  int rx     = 0;
  int ndone  = 0;
  int drops  = 0;

  logic [8:0] q [$];
  int         mcnt  [NI];
  logic [7:0] mword [NI];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_pair(input int s, input logic o0, input logic o1);
    int  k;
    logic lst;
    k = mcnt[s] % 4;
    if (k == 0) mword[s] = 8'h00;
    mword[s][2*k]   = o0;
    mword[s][2*k+1] = o1;
    mcnt[s]++;
    lst = (mcnt[s] == BPS[s]);
    if (k == 3 || lst) begin
      if (q.size() >= DEPTH && !rdy[s]) drops++;
      else q.push_back({lst, mword[s]});
    end
    if (lst) mcnt[s] = 0;
  endtask

  task automatic send(input int s, input logic o0, input logic o1);
    vld[s] = 1'b1;
    en[s]  = 1'b1;
    d0[s]  = o0;
    d1[s]  = o1;
    @(posedge clk);
    #1;
    vld[s] = 1'b0;
    model_pair(s, o0, o1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || mvld[cur]) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drain"}, 32'(q.size() == 0 && !mvld[cur]), 1);
  endtask

  task automatic start(input int s);
    cur   = s;
    rx    = 0;
    ndone = 0;
    drops = 0;
  endtask

  always @(negedge clk) begin
    if (mvld[cur]) begin
      if (q.size() == 0) begin
        check("unexp_word", 1, 0);
      end else begin
        check("data", 32'(mdat[cur]), 32'(q[0][7:0]));
        check("last", 32'(mlst[cur]), 32'(q[0][8]));
        if (rdy[cur]) begin
          void'(q.pop_front());
          rx++;
        end
      end
    end
    if (bdn[cur]) ndone++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic b0, b1;
    for (int i = 0; i < NI; i++) begin
      en[i] = 0; vld[i] = 0; d0[i] = 0; d1[i] = 0; rdy[i] = 1;
      mcnt[i] = 0; mword[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(mvld[0]), 0);
    check("rst_data", 32'(mdat[0]), 0);
    check("rst_last", 32'(mlst[0]), 0);
    check("rst_ovf", 32'(ovf[0]), 0);
    check("rst_done", 32'(bdn[0]), 0);
    check("rst_bcnt", 32'(bcnt[0]), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single full block, alternating pairs
    start(0);
    for (int i = 0; i < 6150; i++) send(0, (i % 2) == 0, (i % 2) == 1);
    drain("t1");
    check("t1_words", 32'(rx), 1538);
    check("t1_done", 32'(ndone), 1);
    check("t1_bcnt", 32'(bcnt[0]), 1);

    // short block, exact multiple of the word size
    start(1);
    for (int i = 0; i < 8; i++) send(1, 1'b1, 1'b1);
    drain("t2");
    check("t2_words", 32'(rx), 2);
    check("t2_bcnt", 32'(bcnt[1]), 1);

    // enable gap between pairs 2 and 3, plus latency
    start(1);
    send(1, 1'b1, 1'b0);
    send(1, 1'b1, 1'b0);
    en[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vld[1] = 1'b1;
      d0[1]  = 1'($urandom_range(0, 1));
      d1[1]  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    vld[1] = 1'b0;
    send(1, 1'b0, 1'b1);
    send(1, 1'b0, 1'b1);
    check("t4_lat0", 32'(mvld[1]), 0);
    @(posedge clk);
    #1;
    check("t4_lat1", 32'(mvld[1]), 1);
    check("t4_word", 32'(mdat[1]), 32'h0000_00A5);
    for (int i = 0; i < 4; i++) send(1, 1'b1, 1'b1);
    drain("t4");
    check("t4_words", 32'(rx), 2);
    check("t4_bcnt", 32'(bcnt[1]), 2);

    // back-to-back blocks; pair 7 lands in the flush cycle
    start(2);
    for (int i = 0; i < 12; i++) begin
      b0 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      send(2, b0, b1);
    end
    drain("t5");
    check("t5_words", 32'(rx), 4);
    check("t5_done", 32'(ndone), 2);
    check("t5_bcnt", 32'(bcnt[2]), 2);

    // backpressure with overflow, random payload
    start(0);
    rdy[0] = 1'b0;
    for (int i = 0; i < 6150; i++) begin
      if (i == 202) rdy[0] = 1'b1;
      b0 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      send(0, b0, b1);
      if (i == 67) check("t3_ovf_pre", 32'(ovf[0]), 0);
      if (i == 68) check("t3_ovf_set", 32'(ovf[0]), 1);
    end
    drain("t3");
    check("t3_words", 32'(rx), 1504);
    check("t3_ovf_sticky", 32'(ovf[0]), 1);
    check("t3_bcnt", 32'(bcnt[0]), 2);

    // reset mid-block with words queued
    start(0);
    rdy[0] = 1'b0;
    for (int i = 0; i < 23; i++) send(0, 1'b1, 1'b0);
    check("t6_queued", 32'(mvld[0]), 1);
    #3;
    rst = 1'b1;
    #1;
    check("t6_valid", 32'(mvld[0]), 0);
    check("t6_data", 32'(mdat[0]), 0);
    check("t6_ovf", 32'(ovf[0]), 0);
    check("t6_bcnt", 32'(bcnt[0]), 0);
    q.delete();
    mcnt[0] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    start(0);
    for (int i = 0; i < 6150; i++) send(0, (i % 2) == 0, (i % 2) == 1);
    drain("t6");
    check("t6_words", 32'(rx), 1538);
    check("t6_done", 32'(ndone), 1);
    check("t6_bcnt2", 32'(bcnt[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/turbo_output_packer.md
Name: turbo_output_packer

Overview:
- Downstream stage of the turbo encoder block. Consumes its serial (out0, out1) bit pairs, qualified by valid and enable.
- Packs four pairs into one 8-bit word and buffers words in a small FIFO. Presents them on a ready/valid stream with a per-code-block last flag.
- Zero-pads the final partial word of each code block and flags encoder-rate overruns.

Parameters:
- BLOCK_PAIRS, 6150, number of (out0, out1) pairs per code block, including termination pairs.
- FIFO_DEPTH, 16, word FIFO depth; must be a power of 2 and at least 4.
- CNT_W, 13, width of the pair counter; must satisfy 2^CNT_W > BLOCK_PAIRS.

Ports:
- clk  in  1  single clock, same domain as the encoder.
- reset  in  1  asynchronous, active-high.
- enable  in  1  capture enable; when low, input pairs are ignored.
- in_valid  in  1  encoder valid; high marks out0/out1 as a live pair this cycle.
- in_out0  in  1  encoder systematic/parity-0 bit.
- in_out1  in  1  encoder parity-1 bit.
- m_data  out  8  packed word.
- m_valid  out  1  m_data is valid.
- m_last  out  1  word is the final word of a code block.
- m_ready  in  1  downstream accepts the word when high with m_valid.
- overflow  out  1  sticky; a pair was dropped because the FIFO was full.
- blk_done  out  1  one-cycle pulse when the last word of a block enters the FIFO.
- blk_count  out  16  number of completed blocks, wraps modulo 2^16.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - m_valid, m_last, overflow and blk_done are 0; m_data is 0; blk_count is 0.
  - Pair counter, pack shift register and FIFO pointers are cleared; FSM goes to IDLE.
- Capture: a pair is taken on a rising clk edge when in_valid && enable.
- Bit order: pair k of a word (k = 0..3) occupies bits m_data[2k] = out0 and m_data[2k+1] = out1.
- FSM states:
  - IDLE: pair counter is 0. The first captured pair moves the FSM to PACK.
  - PACK: accumulates pairs. After the 4th pair of a word, the word is pushed next cycle with m_last = 0. If the captured pair is number BLOCK_PAIRS of the block, go to FLUSH.
  - FLUSH: one cycle. Pushes the final word, zero-filled above the last captured pair, with m_last = 1. Pulses blk_done, increments blk_count, clears the pair counter and returns to IDLE.
  - For BLOCK_PAIRS = 6150, a block is 1537 full words plus 1 partial word holding 2 pairs (bits [7:4] = 0), i.e. 1538 words.
- Capture during FLUSH: the pair counts as pair 1 of the next block and the FSM goes to PACK. No pair is lost across the block boundary.
- Latency: the 4th pair captured at edge N gives m_valid = 1 after edge N+1 if the FIFO was empty (registered FIFO output).
- Output handshake:
  - A word transfers on an edge where m_valid && m_ready.
  - m_data and m_last hold stable while m_valid && !m_ready.
  - m_valid never drops without a transfer.
- FIFO:
  - Tracks occupancy with pointers one bit wider than the address; full = FIFO_DEPTH words.
  - Simultaneous push and pop when full is allowed: the pop frees the slot and no overflow occurs.
  - Push when full without a pop: the word is dropped and overflow is set; it stays set until reset. Packing and counting continue, so block alignment is kept.
- enable low mid-block: capture pauses and the partial word and counter are held. Capture resumes at the next enabled valid pair.
- in_valid while enable is low has no effect.
- Reset mid-block discards the partial word and all FIFO contents; no m_last is emitted for the aborted block.
- blk_count rolls from 0xFFFF to 0x0000.

Decomposition:
- Shared package turbo_pkg holds:
  - PAIRS_PER_WORD = 4 and WORD_W = 8;
  - the FSM state enum {IDLE, PACK, FLUSH};
  - the default BLOCK_PAIRS = 6150, which the encoder and its bench also use.
- One sub-module, turbo_word_fifo: a synchronous FIFO with a 9-bit entry {last, data[7:0]}, push/pop, full/empty and a registered output.
- The packer FSM, shift register and counters stay in the top module.

Test Plan:
- Single block, m_ready held 1, BLOCK_PAIRS = 6150, alternating pairs (1,0),(0,1) -> 1537 words of 0x99, then a last word 0x09 with m_last = 1; blk_done pulses once; blk_count = 1.
- BLOCK_PAIRS = 8, all pairs (1,1), m_ready = 1 -> exactly 2 words of 0xFF; m_last only on the 2nd; no padding word.
- Backpressure: BLOCK_PAIRS = 6150, m_ready = 0 for 200 cycles with FIFO_DEPTH = 16 -> overflow = 1 after the 17th word push. m_data stays stable while stalled. Later words still arrive with m_last on word 1538.
- enable toggled low for 10 cycles between pairs 2 and 3 of a word, pairs (1,0),(1,0),(0,1),(0,1) -> a single word 0xA5; pairs offered during the gap are ignored.
- Back-to-back blocks with a capture in the FLUSH cycle, BLOCK_PAIRS = 6 -> word stream 0x.., last 0x0. (pad), then the next block starts with that pair in bit[1:0]; blk_count = 2 after the second block.
- Reset asserted mid-block after 3 pairs, with 5 words queued -> m_valid = 0 immediately (asynchronous). After release, a fresh block produces an identical word stream to the first-block case.
